// File: rtl/oflow_core_fsm_registration_pkg.sv
// Shared oflow_core definitions: registration FSM state type and the set/PE sizing
// constants common to the FE sequencer and the registration consumer.
package oflow_core_fsm_registration_pkg;

  localparam int PE_NUM          = 24;
  localparam int SET_LEN         = 8;
  localparam int REMAIN_BBOX_LEN = 8;
  localparam int PE_IDX_LEN      = $clog2(PE_NUM);

  typedef enum logic [1:0] {
    idle_st     = 2'd0,
    wait_fe_st  = 2'd1,
    reg_st      = 2'd2,
    set_done_st = 2'd3
  } sm_reg_type;

endpackage

// File: rtl/oflow_core_fsm_registration.sv
// Registration side of the FE/registration handshake: walks the active PEs of each
// finished set through reg_req/reg_ack and reports set and frame completion.
module oflow_core_fsm_registration
  import oflow_core_fsm_registration_pkg::*;
#(
  parameter int PE_NUM          = oflow_core_fsm_registration_pkg::PE_NUM,
  parameter int SET_LEN         = oflow_core_fsm_registration_pkg::SET_LEN,
  parameter int REMAIN_BBOX_LEN = oflow_core_fsm_registration_pkg::REMAIN_BBOX_LEN,
  parameter int PE_IDX_LEN      = $clog2(PE_NUM)
) (
  input  logic                       clk,
  input  logic                       reset_N,
  input  logic                       start_pe,
  input  logic [SET_LEN-1:0]         num_of_sets,
  input  logic [REMAIN_BBOX_LEN-1:0] counter_of_remain_bboxes,
  input  logic                       done_fe,
  output logic                       done_registration,
  output logic [SET_LEN-1:0]         counter_set_reg,
  output logic                       reg_req,
  output logic [PE_IDX_LEN-1:0]      reg_pe_idx,
  input  logic                       reg_ack,
  output logic                       done_frame
);

  localparam int NW = PE_IDX_LEN + 1;

  sm_reg_type            state, state_nxt;
  logic [NW-1:0]         n_act, n_act_nxt, n_new;
  logic [SET_LEN-1:0]    counter_set_nxt, set_cnt_inc;
  logic [PE_IDX_LEN-1:0] reg_pe_idx_nxt;
  logic                  reg_req_nxt, done_registration_nxt, done_frame_nxt;
  logic                  last_set, last_pe;

  // Last-set bbox count: 0 or anything beyond a full set means a full set.
  function automatic logic [NW-1:0] clamp_remain(input logic [REMAIN_BBOX_LEN-1:0] remain);
    logic [NW-1:0] n;
    if ((remain == '0) || (remain > REMAIN_BBOX_LEN'(PE_NUM))) n = NW'(PE_NUM);
    else                                                         n = NW'(remain);
    return n;
  endfunction

  assign last_set    = (num_of_sets != '0) && (counter_set_reg == num_of_sets - SET_LEN'(1));
  assign n_new       = last_set ? clamp_remain(counter_of_remain_bboxes) : NW'(PE_NUM);
  assign last_pe     = ({1'b0, reg_pe_idx} == n_act - NW'(1));
  assign set_cnt_inc = counter_set_reg + SET_LEN'(1);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state             <= idle_st;
      n_act             <= '0;
      counter_set_reg   <= '0;
      reg_pe_idx        <= '0;
      reg_req           <= 1'b0;
      done_registration <= 1'b0;
      done_frame        <= 1'b0;
    end else begin
      state             <= state_nxt;
      n_act             <= n_act_nxt;
      counter_set_reg   <= counter_set_nxt;
      reg_pe_idx        <= reg_pe_idx_nxt;
      reg_req           <= reg_req_nxt;
      done_registration <= done_registration_nxt;
      done_frame        <= done_frame_nxt;
    end
  end

  always_comb begin
    state_nxt             = state;
    n_act_nxt             = n_act;
    counter_set_nxt       = counter_set_reg;
    reg_pe_idx_nxt        = reg_pe_idx;
    reg_req_nxt           = reg_req;
    done_registration_nxt = done_registration;
    done_frame_nxt        = 1'b0;

    case (state)
      idle_st: begin
        if (start_pe && (num_of_sets != '0)) begin
          state_nxt             = wait_fe_st;
          counter_set_nxt       = '0;
          done_registration_nxt = 1'b0;
        end
      end

      wait_fe_st: begin
        done_registration_nxt = (counter_set_reg != '0);
        if (done_fe) begin
          state_nxt             = reg_st;
          done_registration_nxt = 1'b0;
          reg_pe_idx_nxt        = '0;
          reg_req_nxt           = 1'b1;
          n_act_nxt             = n_new;
        end
      end

      reg_st: begin
        // An ack only counts against an outstanding request.
        if (reg_req && reg_ack) begin
          if (last_pe) begin
            reg_req_nxt = 1'b0;
            state_nxt   = set_done_st;
          end else begin
            reg_pe_idx_nxt = reg_pe_idx + PE_IDX_LEN'(1);
          end
        end
      end

      set_done_st: begin
        counter_set_nxt       = set_cnt_inc;
        done_registration_nxt = 1'b1;
        if (set_cnt_inc == num_of_sets) begin
          done_frame_nxt = 1'b1;
          state_nxt      = idle_st;
        end else begin
          state_nxt = wait_fe_st;
        end
      end

      default: state_nxt = idle_st;
    endcase
  end

endmodule
